updown_counter_param: RTL
=========================

# updown_counter_param

Parametrised up/down counter and the next generation of the 8-bit E/M counter. It generalises width and modulus, and adds four behaviours:
- synchronous parallel load
- a count prescaler
- optional saturation instead of wrap-around
- a registered one-cycle wrap pulse

With default parameters it is a drop-in superset of the 8-bit counter: same `Clk`/`Reset`/`E`/`M`/`Q`/`Cout` behaviour. It serves as the shared counting primitive for timers, dividers and address generators.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits; legal range 2..32.
- `MODULUS`, default 2**`WIDTH`: count range, 2 ≤ `MODULUS` ≤ 2**`WIDTH`. `MAX_VAL` = `MODULUS` - 1.
- `PRESCALE`, default 1: number of enabled cycles per count step, 1..65535.
- `SATURATE`, default 0: 0 = wrap at the range ends; 1 = hold at `MAX_VAL` counting up and at 0 counting down.

Ports:
- `Clk`, input, 1: the only clock; all state updates on its rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `E`, input, 1: count enable.
- `M`, input, 1: direction; 1 = up, 0 = down.
- `Load`, input, 1: synchronous parallel load; has priority over `E`.
- `D`, input, `WIDTH`: load value.
- `Q`, output, `WIDTH`: counter value (registered).
- `Cout`, output, 1: combinational; `Q` == `MAX_VAL`, independent of `E` and `M`.
- `Bout`, output, 1: combinational; `Q` == 0, independent of `E` and `M`.
- `Wrap`, output, 1: registered; one-cycle pulse marking a wrap-around.

## Operation
- Internal state:
  - `Q`
  - prescale counter `pre_cnt`, width clog2(`PRESCALE`) with a minimum of 1
  - `Wrap` flop
- Reset (`Reset` = 0): immediately, without waiting for a clock edge, `Q` = 0, `pre_cnt` = 0, `Wrap` = 0. Hence `Cout` = 0 and `Bout` = 1 while in reset.
- Priority at each rising edge: `Reset` > `Load` > `E` > hold.
- Load (`Load` = 1):
  - `Q` ← `D` if `D` ≤ `MAX_VAL`, otherwise `Q` ← `MAX_VAL` (clamped).
  - `pre_cnt` ← 0 and `Wrap` ← 0.
  - `E` and `M` are ignored in this cycle.
- Enabled cycle (`Load` = 0, `E` = 1):
  - If `pre_cnt` == `PRESCALE` - 1: perform a step, then `pre_cnt` ← 0.
  - Otherwise: `pre_cnt` ← `pre_cnt` + 1 and `Q` holds.
  - With `PRESCALE` = 1 every enabled cycle is a step.
- Step, up (`M` = 1):
  - `Q` < `MAX_VAL`: `Q` + 1.
  - `Q` == `MAX_VAL`: `Q` ← 0 with `Wrap` ← 1 when `SATURATE` = 0; `Q` holds with `Wrap` ← 0 when `SATURATE` = 1.
- Step, down (`M` = 0):
  - `Q` > 0: `Q` - 1.
  - `Q` == 0: `Q` ← `MAX_VAL` with `Wrap` ← 1 when `SATURATE` = 0; `Q` holds with `Wrap` ← 0 when `SATURATE` = 1.
- Any edge that is not a wrapping step sets `Wrap` ← 0, so `Wrap` is never high for two consecutive cycles unless consecutive steps both wrap.
- Hold (`E` = 0, `Load` = 0): `Q` and `pre_cnt` are frozen, so a partial prescale count is preserved. `Wrap` ← 0.
- Changing `M` mid-prescale does not touch `pre_cnt`; the direction is sampled only at step edges.
- Arithmetic is modulo `MODULUS`, not 2**`WIDTH`. `Q` never exceeds `MAX_VAL` in any sequence.

## Timing
- `Q` updates at the rising edge of `Clk`.
- `Cout` and `Bout` follow `Q` combinationally in the same cycle.
- Latency:
  - `Load` → `Q`: 1 edge.
  - `E` asserted → first step: `PRESCALE` edges, counted from `pre_cnt` = 0.
  - `Wrap` is high during the cycle following the wrapping edge, aligned with the new `Q`.
- Reset assertion takes effect asynchronously, mid-cycle or mid-prescale included.
- On deassertion, the first possible update is the next rising edge. Reset-release synchronisation is provided upstream.
- Inputs sampled at the rising edge. Bench drives and checks at the falling edge.

## Test plan
- Default parameters, reset, then `E`=1 `M`=1 for 5 edges → `Q`=05. Then `E`=0 for 5 edges → `Q`=05 held. Then `M`=0 for 3 edges → `Q`=02.
- Default parameters, count up from 0 for 255 edges → `Q`=FF with `Cout`=1. One more edge → `Q`=00, `Wrap`=1 for exactly one cycle, `Bout`=1. From 00 with `M`=0, one edge → `Q`=FF and `Wrap`=1.
- `MODULUS`=10, `PRESCALE`=3, counting up from 0 → `Q` advances every 3rd edge. 9 → 0 occurs at edge 30 with `Wrap`=1. Deasserting `E` after 2 prescale edges and re-enabling for 1 edge → step occurs.
- `MODULUS`=10: `Load`=1 with `D`=0x0C → `Q`=9 and `Cout`=1. `Load` and `E` high together with `D`=4 → `Q`=4, no step.
- `SATURATE`=1, default width: `Q`=FF counting up for 3 edges → `Q`=FF, `Wrap`=0. `Q`=00 counting down → `Q`=00, `Wrap`=0.
- Assert `Reset`=0 midway between edges while `Q`=7 and `pre_cnt`≠0 → `Q`=0 immediately, `Bout`=1. After release, a full `PRESCALE` edges pass before the first step.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with synchronous load, count prescaler,
// optional saturation and a registered wrap pulse.
module updown_counter_param #(
    parameter int             WIDTH    = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter int             PRESCALE = 1,
    parameter bit             SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             E,
    input  logic             M,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Cout,
    output logic             Bout,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap_q, wrap_d;

    // NOTE: every next-state signal gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        q_d    = q_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (Load) begin
            q_d   = (D > MAX_VAL) ? MAX_VAL : D;
            pre_d = '0;
        end else if (E) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (M) begin
                    if (q_q != MAX_VAL) begin
                        q_d = q_q + WIDTH'(1);
                    end else if (!SATURATE) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    if (q_q != '0) begin
                        q_d = q_q - WIDTH'(1);
                    end else if (!SATURATE) begin
                        q_d    = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end
            end else begin
                // Direction is not looked at until the prescaler reaches its last count.
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            q_q    <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign Cout = (q_q == MAX_VAL);
    assign Bout = (q_q == '0);
    assign Wrap = wrap_q;

endmodule
